// File: rtl/stage1_hazard_issue_pkg.sv
// -----------------------------------------------------------------------------
// bpf_defs: shared BPF encoding constants for the CPU pipeline.
//   - instruction field placement inside the 64-bit {code, jt, jf, k} word
//   - instruction class codes (code[2:0])
//   - encodings that decide which of A/X an instruction reads
//   - stage1 holding-register state type
// No ports (package).
// -----------------------------------------------------------------------------
package bpf_defs;

    localparam int INSTR_W  = 64;
    localparam int CODE_LSB = 48;
    localparam int CODE_W   = 16;

    localparam logic [2:0] BPF_LD   = 3'd0;
    localparam logic [2:0] BPF_LDX  = 3'd1;
    localparam logic [2:0] BPF_ST   = 3'd2;
    localparam logic [2:0] BPF_STX  = 3'd3;
    localparam logic [2:0] BPF_ALU  = 3'd4;
    localparam logic [2:0] BPF_JMP  = 3'd5;
    localparam logic [2:0] BPF_RET  = 3'd6;
    localparam logic [2:0] BPF_MISC = 3'd7;

    // code[7:5] addressing mode that indexes memory through X
    localparam logic [2:0] BPF_IND   = 3'b010;
    // code[7:4] jump op for the unconditional jump
    localparam logic [3:0] BPF_JA    = 4'h0;
    // code[4:3] return-value source selecting A
    localparam logic [1:0] BPF_RET_A = 2'b10;
    // code[7:3] MISC sub-ops
    localparam logic [4:0] BPF_TAX   = 5'b00000;
    localparam logic [4:0] BPF_TXA   = 5'b10000;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/stage1_hazard_issue_if.sv
// -----------------------------------------------------------------------------
// stage1_hazard_issue_if: instruction path through stage1.
//   instr_in/pc_in/valid_in : instruction from stage0
//   ready                   : stage1 can accept this cycle
//   instr_out/pc_out/valid_out : instruction issued to stage2 (0 valid = bubble)
// modport slave  : the stage1 block
// modport master : the surrounding pipeline (stage0 producer / stage2 consumer)
// -----------------------------------------------------------------------------
interface stage1_hazard_issue_if
    import bpf_defs::*;
#(
    parameter int PC_W = 10
);
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc_in;
    logic               valid_in;
    logic               ready;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic               valid_out;

    modport slave (
        input  instr_in, pc_in, valid_in,
        output ready, instr_out, pc_out, valid_out
    );

    modport master (
        output instr_in, pc_in, valid_in,
        input  ready, instr_out, pc_out, valid_out
    );
endinterface

// File: rtl/stage1_hazard_issue_decode.sv
// -----------------------------------------------------------------------------
// bpf_reg_read_decode: combinational decode of which accumulator registers a
// BPF instruction reads.
//   code    in  16  instruction code field
//   reads_a out 1   instruction reads A
//   reads_x out 1   instruction reads X
// -----------------------------------------------------------------------------
module bpf_reg_read_decode
    import bpf_defs::*;
(
    input  logic [15:0] code,
    output logic        reads_a,
    output logic        reads_x
);
    logic unused_code_hi;
    logic is_ja;

    assign unused_code_hi = ^code[15:8];
    assign is_ja          = (code[7:4] == BPF_JA);

    always_comb begin
        reads_a = 1'b0;
        reads_x = 1'b0;
        case (code[2:0])
            BPF_LD:   reads_x = (code[7:5] == BPF_IND);
            BPF_LDX:  ;
            BPF_ST:   reads_a = 1'b1;
            BPF_STX:  reads_x = 1'b1;
            BPF_ALU: begin
                reads_a = 1'b1;
                reads_x = code[3];
            end
            BPF_JMP: begin
                reads_a = ~is_ja;
                reads_x = code[3] & ~is_ja;
            end
            BPF_RET:  reads_a = (code[4:3] == BPF_RET_A);
            default: begin
                reads_a = (code[7:3] == BPF_TAX);
                reads_x = (code[7:3] == BPF_TXA);
            end
        endcase
    end
endmodule

// File: rtl/stage1_hazard_issue.sv
// -----------------------------------------------------------------------------
// stage1_hazard_issue: holds one instruction from stage0 and issues it to
// stage2 only when no downstream stage (2, 2.5, 3) still has a pending write
// to a register the instruction reads; bubbles are inserted otherwise.
//   clk, rst        clock, asynchronous active-high reset
//   io (slave)      stage0 handshake in, registered issue to stage2 out
//   s2/s25/s3_A_en  valid-qualified pending writes of A per downstream stage
//   s2/s25/s3_X_en  valid-qualified pending writes of X per downstream stage
//   flush           taken branch: discard held and incoming instruction
//   stats_clr       synchronous clear of stall_cycles
//   stall_cycles    saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module stage1_hazard_issue
    import bpf_defs::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 32
)(
    input  logic              clk,
    input  logic              rst,
    stage1_hazard_issue_if.slave io,
    input  logic              s2_A_en,
    input  logic              s2_X_en,
    input  logic              s25_A_en,
    input  logic              s25_X_en,
    input  logic              s3_A_en,
    input  logic              s3_X_en,
    input  logic              flush,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  stall_cycles
);
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hold_state_t        state;
    logic [INSTR_W-1:0] hold_instr_p0;
    logic [PC_W-1:0]    hold_pc_p0;
    logic               hold_vld_p0;
    logic [INSTR_W-1:0] instr_p1;
    logic [PC_W-1:0]    pc_p1;
    logic               vld_p1;
    logic [CNT_W-1:0]   stall_cnt;

    logic reads_a, reads_x;
    logic hazard, issue, ready, accept;

    bpf_reg_read_decode u_decode (
        .code    (hold_instr_p0[CODE_LSB +: CODE_W]),
        .reads_a (reads_a),
        .reads_x (reads_x)
    );

    // Stage3 is included: its write only becomes visible to stage2 after the edge.
    assign hold_vld_p0 = (state == ST_HELD);
    assign hazard = (reads_a & (s2_A_en | s25_A_en | s3_A_en)) |
                    (reads_x & (s2_X_en | s25_X_en | s3_X_en));
    assign issue  = hold_vld_p0 & ~hazard & ~flush;
    assign ready  = ~hold_vld_p0 | issue | flush;
    assign accept = io.valid_in & ready & ~flush;

    // ---- stage p0: holding register (stage0 -> stage1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            vld_p1 <= 1'b0;
        end else if (flush) begin
            state  <= ST_EMPTY;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
            case (state)
                ST_EMPTY: if (accept) state <= ST_HELD;
                default:  if (!accept && issue) state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_instr_p0 <= io.instr_in;
            hold_pc_p0    <= io.pc_in;
        end
    end

    // ---- stage p1: issue register (stage1 -> stage2) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_p1 <= '0;
            pc_p1    <= '0;
        end else if (issue) begin
            instr_p1 <= hold_instr_p0;
            pc_p1    <= hold_pc_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stats_clr)
            stall_cnt <= '0;
        else if (hold_vld_p0 && hazard && !flush)
            stall_cnt <= sat_inc(stall_cnt);
    end

    assign io.ready     = ready;
    assign io.instr_out = instr_p1;
    assign io.pc_out    = pc_p1;
    assign io.valid_out = vld_p1;
    assign stall_cycles = stall_cnt;
endmodule

// File: tb/tb_stage1_hazard_issue.sv
module tb_stage1_hazard_issue;
    localparam int PC_W  = 10;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s2_A_en = 0, s2_X_en = 0, s25_A_en = 0, s25_X_en = 0, s3_A_en = 0, s3_X_en = 0;
    logic flush = 0, stats_clr = 0;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    stage1_hazard_issue_if #(.PC_W(PC_W)) bus ();

    stage1_hazard_issue #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .io           (bus),
        .s2_A_en      (s2_A_en),
        .s2_X_en      (s2_X_en),
        .s25_A_en     (s25_A_en),
        .s25_X_en     (s25_X_en),
        .s3_A_en      (s3_A_en),
        .s3_X_en      (s3_X_en),
        .flush        (flush),
        .stats_clr    (stats_clr),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] code, input logic [PC_W-1:0] pc);
        bus.valid_in = v;
        bus.instr_in = {code, 16'h0000, 22'd0, pc};
        bus.pc_in    = pc;
    endtask

    task automatic set_en(input logic [5:0] en);
        {s2_A_en, s2_X_en, s25_A_en, s25_X_en, s3_A_en, s3_X_en} = en;
    endtask

    initial begin
        drive(1'b0, 16'h0000, '0);
        #1 rst = 1'b1;
        #2;
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_instr_out", bus.instr_out, 64'd0);
        chk("rst_pc_out", 64'(bus.pc_out), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        #9 rst = 1'b0;
        tick();

        // 1: six back-to-back ALU ADD K, no hazards
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'h0004, PC_W'(i + 1));
            #0 chk("t1_ready", 64'(bus.ready), 64'd1);
            tick();
            if (i == 0) begin
                chk("t1_first_bubble", 64'(bus.valid_out), 64'd0);
            end else begin
                chk("t1_valid", 64'(bus.valid_out), 64'd1);
                chk("t1_pc", 64'(bus.pc_out), 64'(i));
            end
        end
        drive(1'b0, 16'h0000, '0);
        tick();
        chk("t1_valid_last", 64'(bus.valid_out), 64'd1);
        chk("t1_pc_last", 64'(bus.pc_out), 64'd6);
        chk("t1_instr_last", bus.instr_out, {16'h0004, 16'h0000, 22'd0, 10'd6});
        tick();
        chk("t1_drain", 64'(bus.valid_out), 64'd0);

        // 2: ALU ADD X stalled two cycles on stage2.5 X write
        drive(1'b1, 16'h000C, 10'd20);
        tick();
        drive(1'b0, 16'h0000, '0);
        set_en(6'b000100);
        #0 chk("t2_ready_stall1", 64'(bus.ready), 64'd0);
        tick();
        chk("t2_bubble1", 64'(bus.valid_out), 64'd0);
        chk("t2_ready_stall2", 64'(bus.ready), 64'd0);
        tick();
        chk("t2_bubble2", 64'(bus.valid_out), 64'd0);
        set_en(6'b000000);
        #0 chk("t2_ready_issue", 64'(bus.ready), 64'd1);
        tick();
        chk("t2_valid", 64'(bus.valid_out), 64'd1);
        chk("t2_pc", 64'(bus.pc_out), 64'd20);
        chk("t2_stall", 64'(stall_cycles), 64'd2);

        // 3: LDX IMM ignores every pending write; RET A stalls once on stage3 A
        drive(1'b1, 16'h0001, 10'd30);
        set_en(6'b111111);
        tick();
        drive(1'b0, 16'h0000, '0);
        chk("t3_ldx_ready", 64'(bus.ready), 64'd1);
        tick();
        chk("t3_ldx_valid", 64'(bus.valid_out), 64'd1);
        chk("t3_ldx_pc", 64'(bus.pc_out), 64'd30);
        chk("t3_ldx_stall", 64'(stall_cycles), 64'd2);
        set_en(6'b000010);
        drive(1'b1, 16'h0016, 10'd31);
        tick();
        drive(1'b0, 16'h0000, '0);
        tick();
        chk("t3_ret_bubble", 64'(bus.valid_out), 64'd0);
        chk("t3_ret_stall", 64'(stall_cycles), 64'd3);
        set_en(6'b000000);
        tick();
        chk("t3_ret_valid", 64'(bus.valid_out), 64'd1);
        chk("t3_ret_pc", 64'(bus.pc_out), 64'd31);

        // 4: flush while TXA stalled on stage2 X, with a new instruction offered
        drive(1'b1, 16'h0087, 10'd40);
        set_en(6'b010000);
        tick();
        drive(1'b0, 16'h0000, '0);
        tick();
        chk("t4_stall", 64'(stall_cycles), 64'd4);
        flush = 1'b1;
        drive(1'b1, 16'h0004, 10'd41);
        #0 chk("t4_ready_flush", 64'(bus.ready), 64'd1);
        tick();
        chk("t4_flush_bubble", 64'(bus.valid_out), 64'd0);
        chk("t4_stall_frozen", 64'(stall_cycles), 64'd4);
        flush = 1'b0;
        drive(1'b0, 16'h0000, '0);
        set_en(6'b000000);
        #0 chk("t4_ready_empty", 64'(bus.ready), 64'd1);
        tick();
        chk("t4_no_txa", 64'(bus.valid_out), 64'd0);
        tick();
        chk("t4_no_dropped", 64'(bus.valid_out), 64'd0);
        chk("t4_pc_kept", 64'(bus.pc_out), 64'd31);

        // 5: saturation of the 4-bit stall counter, then clear while stalled
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("t5_clr0", 64'(stall_cycles), 64'd0);
        drive(1'b1, 16'h0002, 10'd50);
        set_en(6'b100000);
        tick();
        drive(1'b0, 16'h0000, '0);
        for (int i = 0; i < 20; i++) tick();
        chk("t5_saturated", 64'(stall_cycles), 64'd15);
        chk("t5_still_bubble", 64'(bus.valid_out), 64'd0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("t5_clr_prio", 64'(stall_cycles), 64'd0);
        tick();
        chk("t5_recount1", 64'(stall_cycles), 64'd1);
        tick();
        chk("t5_recount2", 64'(stall_cycles), 64'd2);

        // 6: asynchronous reset mid-stall
        #3 rst = 1'b1;
        #1;
        chk("t6_valid_out", 64'(bus.valid_out), 64'd0);
        chk("t6_stall", 64'(stall_cycles), 64'd0);
        chk("t6_pc_out", 64'(bus.pc_out), 64'd0);
        chk("t6_instr_out", bus.instr_out, 64'd0);
        chk("t6_ready", 64'(bus.ready), 64'd1);
        #2 rst = 1'b0;
        set_en(6'b000000);
        drive(1'b1, 16'h0004, 10'd60);
        tick();
        drive(1'b0, 16'h0000, '0);
        chk("t6_st_dropped", 64'(bus.valid_out), 64'd0);
        tick();
        chk("t6_new_valid", 64'(bus.valid_out), 64'd1);
        chk("t6_new_pc", 64'(bus.pc_out), 64'd60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage1_hazard_issue.md
Name: stage1_hazard_issue

Overview:
- Consumer end of the pending-write stall signals in the BPF CPU pipeline.
- Downstream stages 2, 2.5 and 3 each publish valid-qualified A_en/X_en. This block holds the instruction fetched by stage0 and decodes which of A/X it reads.
- It withholds issue to stage2, inserting bubbles, while any downstream stage still has a pending write to a register the instruction reads.
- It also handles branch flush and keeps a saturating stall-cycle counter.

Parameters:
- PC_W, 10, width of the PC tag carried alongside each instruction.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock. One clock domain; all logic on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- instr_in  in  64  BPF instruction {code[15:0], jt[7:0], jf[7:0], k[31:0]} from stage0.
- pc_in  in  PC_W  PC of instr_in.
- valid_in  in  1  instr_in/pc_in valid.
- ready  out  1  may accept from stage0 this cycle (combinational).
- s2_A_en, s2_X_en  in  1 each  stage2 pending writes, already qualified by stage2 valid.
- s25_A_en, s25_X_en  in  1 each  stage2.5 pending writes, already valid-qualified.
- s3_A_en, s3_X_en  in  1 each  stage3 pending writes, already valid-qualified.
- flush  in  1  taken branch from stage3; discard everything held.
- stats_clr  in  1  synchronous clear of stall_cycles.
- instr_out  out  64  instruction issued to stage2 (registered).
- pc_out  out  PC_W  PC of instr_out (registered).
- valid_out  out  1  instr_out valid (registered); 0 = bubble.
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async, rst=1): hold_valid=0, valid_out=0, instr_out=0, pc_out=0, stall_cycles=0; ready therefore reads 1.
- State: one holding register {hold_instr, hold_pc} plus hold_valid. Two states:
  - EMPTY: hold_valid=0.
  - HELD: hold_valid=1.
- Read decode, combinational on hold_instr code; cls=code[2:0]:
  - LD(0): reads X iff mode code[7:5]==3'b010 (IND).
  - LDX(1): reads nothing.
  - ST(2): reads A.
  - STX(3): reads X.
  - ALU(4): reads A; also reads X iff code[3]=1.
  - JMP(5): reads A unless code[7:4]==0 (JA); reads X iff code[3]=1 and not JA.
  - RET(6): reads A iff code[4:3]==2'b10.
  - MISC(7): TAX (code[7:3]==0) reads A; TXA (code[7:3]==5'b10000) reads X; other encodings read nothing.
- Hazard: hazard = (readsA & (s2_A_en|s25_A_en|s3_A_en)) | (readsX & (s2_X_en|s25_X_en|s3_X_en)).
  - Stage3 counts as pending because its write is not visible to stage2 until after the edge.
- issue = hold_valid & ~hazard & ~flush.
- ready = ~hold_valid | issue | flush.
- Each posedge, flush=0:
  - valid_out <= issue.
  - If issue: instr_out/pc_out <= hold contents. Otherwise instr_out/pc_out hold their old value, don't-care.
  - If valid_in & ready: hold <= {instr_in, pc_in}, hold_valid <= 1. Else if issue: hold_valid <= 0. Else hold unchanged (stall).
- Flush (highest priority): valid_out <= 0, hold_valid <= 0, and any valid_in that cycle is dropped, not captured.
- Latency: accepted at edge N → valid_out=1 after edge N+1 with no hazard. Full throughput of 1 instr/cycle with no hazards.
- stall_cycles:
  - stats_clr → 0 (takes priority over increment).
  - Else +1 on cycles with hold_valid & hazard & ~flush.
  - Saturates at 2^CNT_W-1; never wraps.
- Simultaneous issue and accept: hold replaced with the new instruction, no bubble.
- Hazard inputs that change mid-stall are re-evaluated every cycle; the instruction issues the first cycle hazard=0.
- Reset asserted mid-stall drops the held instruction immediately (asynchronously); valid_out=0 until after the first edge following deassertion.

Decomposition:
- Shared package bpf_defs: class codes (BPF_LD..BPF_MISC), mode IND, JA op, RET A source, TAX/TXA encodings, instruction field offsets.
- Sub-module bpf_reg_read_decode: combinational code[15:0] → {readsA, readsX}. Reusable by other stages.

Test Plan:
1. Six back-to-back ALU ADD K (code 0x0004), all *_en=0 → valid_out high six consecutive cycles starting one edge after first accept; ready constant 1; pc_out sequence matches input.
2. ALU ADD X (0x000C) held with s25_X_en=1 for 2 cycles, then 0 → two bubbles (valid_out=0); ready=0 during stall; issue on third cycle; stall_cycles=2.
3. LDX IMM (0x0000|1=0x0001) with all six *_en=1 → no stall, issued next cycle, stall_cycles unchanged. RET A (0x0016) with s3_A_en=1 → one stall.
4. Flush while TXA (0x0087) stalled on s2_X_en, valid_in=1 same cycle → next cycle valid_out=0, hold empty, incoming instruction not issued later; ready=1.
5. CNT_W=4, ST (0x0002) held with s2_A_en=1 for 20 cycles → stall_cycles=15 (saturated). stats_clr pulse while still stalled → 0, then increments again.
6. Assert rst asynchronously mid-stall (between edges) → valid_out, stall_cycles, pc_out, instr_out read 0 immediately; ready=1. After release, a new instruction issues normally.
